keypad_scanner: RTL and testbench

- Scans a 4x4 active-low key matrix and produces a debounced key code with a one-cycle valid strobe.
- Sits directly downstream of the frequency divider: the divider's square-wave output is the scan-rate input here.
- Each rising edge of that input is one scan/debounce step.
- The key code feeds the frequency-select logic.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/sync_ff.sv | 30 +++
 rtl/keypad_scanner.sv | 152 +++++++++++++++
 tb/tb_keypad_scanner.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// Provides matrix geometry, counter width, FSM state constants, the
// key-code payload layout and the column priority picker.
package keypad_pkg;

   localparam int unsigned KP_ROWS = 4;
   localparam int unsigned KP_COLS = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ROW_W   = $clog2(KP_ROWS);
   localparam int unsigned COL_W   = $clog2(KP_COLS);

   localparam logic [1:0] SCAN     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   // Key code as presented downstream: row in the upper bits, column below.
   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } key_code_t;

   // Lowest-index active-low column; higher pressed columns are ignored.
   function automatic logic [COL_W-1:0] first_low(input logic [KP_COLS-1:0] cols);
      logic [COL_W-1:0] idx;
      idx = '0;
      for (int i = int'(KP_COLS) - 1; i >= 0; i--) begin
         if (!cols[i]) idx = COL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser, reset value all-ones (idle level of the
// pulled-up, active-low matrix columns).
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input bus
//   q          : synchronised output, STAGES clocks behind d
module sync_ff #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   // Shift chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STAGES); i++) stage[i] <= '1;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Each rising edge of scan_in (the divided scan clock) is one scan step.
//   clk, rst_n : system clock, async active-low reset
//   ena        : step enable; when low all state is frozen
//   scan_in    : divided scan clock, same domain as clk
//   col_n      : matrix columns, active-low, asynchronous
//   row_n      : row drive, exactly one bit low
//   key_code   : accepted key, row*4+col
//   key_valid  : one-clk strobe on acceptance
//   key_held   : high from acceptance until release is debounced
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                scan_in,
   input  logic [KP_COLS-1:0]  col_n,
   output logic [KP_ROWS-1:0]  row_n,
   output logic [3:0]          key_code,
   output logic                key_valid,
   output logic                key_held
);

   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

   logic               scan_d;
   logic               step;
   logic [KP_COLS-1:0] col_s;

   logic [1:0]         state,    state_nx;
   logic [ROW_W-1:0]   row_idx,  row_idx_nx;
   logic [CNT_W-1:0]   cnt,      cnt_nx;
   key_code_t          cand,     cand_nx;
   logic [3:0]         key_code_nx;
   logic               key_valid_nx;
   logic               key_held_nx;

   logic               any_low;
   logic               cand_down;
   logic [CNT_W-1:0]   cnt_inc;

   // Column synchroniser.
   sync_ff #(
      .WIDTH  (KP_COLS),
      .STAGES (SYNC_STAGES)
   ) u_col_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (col_n),
      .q     (col_s)
   );

   // Step = rising edge of scan_in, qualified by ena.
   assign step      = scan_in & ~scan_d & ena;
   assign any_low   = ~(&col_s);
   assign cand_down = ~col_s[cand.col];
   assign cnt_inc   = cnt + CNT_W'(1);

   // Next-state and output decode; everything holds between steps.
   always_comb begin
      state_nx     = state;
      row_idx_nx   = row_idx;
      cnt_nx       = cnt;
      cand_nx      = cand;
      key_code_nx  = key_code;
      key_valid_nx = 1'b0;
      key_held_nx  = key_held;

      if (step) begin
         case (state)
            SCAN: begin
               if (any_low) begin
                  cand_nx.row = row_idx;
                  cand_nx.col = first_low(col_s);
                  cnt_nx      = CNT_W'(1);
                  state_nx    = DEBOUNCE;
               end else begin
                  row_idx_nx = row_idx + ROW_W'(1);
               end
            end
            DEBOUNCE: begin
               if (cand_down) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     key_code_nx  = cand;
                     key_valid_nx = 1'b1;
                     key_held_nx  = 1'b1;
                     cnt_nx       = '0;
                     state_nx     = HELD;
                  end
               end else begin
                  // Bounce: rescan the same row.
                  cnt_nx   = '0;
                  state_nx = SCAN;
               end
            end
            HELD: begin
               if (!cand_down) begin
                  cnt_nx   = CNT_W'(1);
                  state_nx = RELEASE;
               end
            end
            RELEASE: begin
               if (!cand_down) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     key_held_nx = 1'b0;
                     cnt_nx      = '0;
                     row_idx_nx  = row_idx + ROW_W'(1);
                     state_nx    = SCAN;
                  end
               end else begin
                  // Release glitch: back to held without a new strobe.
                  cnt_nx   = '0;
                  state_nx = HELD;
               end
            end
            default: state_nx = SCAN;
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_d    <= 1'b0;
         state     <= SCAN;
         row_idx   <= '0;
         cnt       <= '0;
         cand      <= '0;
         row_n     <= 4'b1110;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         scan_d    <= scan_in;
         state     <= state_nx;
         row_idx   <= row_idx_nx;
         cnt       <= cnt_nx;
         cand      <= cand_nx;
         row_n     <= ~(KP_ROWS'(1) << row_idx_nx);
         key_code  <= key_code_nx;
         key_valid <= key_valid_nx;
         key_held  <= key_held_nx;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: an ideal 4x4 key matrix driven
// from a press table, a step-level behavioural model compared every clock,
// directed scenarios with literal expectations, then randomized traffic.
module tb_keypad_scanner;

   localparam int DT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       scan_in = 1'b0;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   bit pressed [4][4];

   int checks = 0;
   int errors = 0;
   int steps_done = 0;
   int nvalid = 0;
   int valid_step = -1;
   bit cmp_en = 1'b0;

   // Model of the scanner, one update per accepted scan step.
   int         m_row = 0;
   int         m_mode = 0;   // 0 scanning, 1 confirming press, 2 held, 3 confirming release
   int         m_run = 0;
   int         trk_r = 0;
   int         trk_c = 0;
   logic [3:0] m_code = 4'd0;
   bit         m_valid = 1'b0;
   bit         m_held = 1'b0;
   bit         m_prev = 1'b0;

   keypad_scanner #(.DEBOUNCE_TICKS(DT), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .scan_in   (scan_in),
      .col_n     (col_n),
      .row_n     (row_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Ideal matrix: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
   end

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int lowest_pressed(input int r);
      for (int c = 0; c < 4; c++) if (pressed[r][c]) return c;
      return -1;
   endfunction

   function automatic void model_step();
      int c;
      bit down;
      case (m_mode)
         0: begin
            c = lowest_pressed(m_row);
            if (c >= 0) begin
               trk_r = m_row; trk_c = c; m_run = 1; m_mode = 1;
            end else begin
               m_row = (m_row + 1) % 4;
            end
         end
         1: begin
            if (pressed[trk_r][trk_c]) begin
               m_run++;
               if (m_run == DT) begin
                  m_code = 4'(trk_r * 4 + trk_c);
                  m_valid = 1'b1; m_held = 1'b1; m_mode = 2;
               end
            end else begin
               m_mode = 0;
            end
         end
         2: begin
            if (!pressed[trk_r][trk_c]) begin m_run = 1; m_mode = 3; end
         end
         default: begin
            down = pressed[trk_r][trk_c];
            if (!down) begin
               m_run++;
               if (m_run == DT) begin
                  m_held = 1'b0; m_mode = 0; m_row = (m_row + 1) % 4;
               end
            end else begin
               m_mode = 2;
            end
         end
      endcase
   endfunction

   // Model update process.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_row = 0; m_mode = 0; m_run = 0; m_code = 4'd0;
            m_valid = 1'b0; m_held = 1'b0; m_prev = 1'b0;
         end else begin
            m_valid = 1'b0;
            if (scan_in && !m_prev && ena) model_step();
            m_prev = scan_in;
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("row_n", row_n, 4'hF ^ (4'b0001 << m_row));
            chk("key_code", key_code, m_code);
            chk("key_valid", 4'(key_valid), 4'(m_valid));
            chk("key_held", 4'(key_held), 4'(m_held));
            if (key_valid) begin
               nvalid++;
               valid_step = steps_done;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      scan_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      steps_done = 0;
      nvalid = 0;
      valid_step = -1;
   endtask

   // One scan period: 4 clk low, then rising edge and 4 clk high.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         scan_in = 1'b0;
         repeat (4) @(negedge clk);
         scan_in = 1'b1;
         steps_done++;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic clear_keys();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
   endtask

   logic [3:0] row_seq [4];

   initial begin
      row_seq[0] = 4'b1101; row_seq[1] = 4'b1011;
      row_seq[2] = 4'b0111; row_seq[3] = 4'b1110;
      clear_keys();
      ena = 1'b1;
      do_reset();
      cmp_en = 1'b1;

      // Reset values and idle row rotation.
      chk("rst row_n", row_n, 4'b1110);
      chk("rst key_code", key_code, 4'd0);
      chk("rst key_valid", 4'(key_valid), 4'd0);
      chk("rst key_held", 4'(key_held), 4'd0);
      for (int k = 0; k < 8; k++) begin
         step(1);
         chk("idle row", row_n, row_seq[k % 4]);
      end
      chk("idle nvalid", 4'(nvalid), 4'd0);

      // Key (2,1): detected on step 3, accepted on step 6.
      do_reset();
      pressed[2][1] = 1'b1;
      step(10);
      chk("k9 nvalid", 4'(nvalid), 4'd1);
      chk("k9 valid_step", 4'(valid_step), 4'd6);
      chk("k9 code", key_code, 4'd9);
      chk("k9 held", 4'(key_held), 4'd1);

      // Release with a one-step glitch.
      pressed[2][1] = 1'b0;
      step(2);
      chk("glitch held a", 4'(key_held), 4'd1);
      pressed[2][1] = 1'b1;
      step(1);
      chk("glitch held b", 4'(key_held), 4'd1);
      pressed[2][1] = 1'b0;
      step(3);
      chk("glitch held c", 4'(key_held), 4'd1);
      step(1);
      chk("release held", 4'(key_held), 4'd0);
      chk("release row", row_n, 4'b0111);
      chk("release nvalid", 4'(nvalid), 4'd1);

      // Bounce on (0,3): two pressed steps then released.
      do_reset();
      pressed[0][3] = 1'b1;
      step(2);
      pressed[0][3] = 1'b0;
      step(1);
      chk("bounce row", row_n, 4'b1110);
      chk("bounce nvalid", 4'(nvalid), 4'd0);
      chk("bounce held", 4'(key_held), 4'd0);
      step(1);

      // Two keys on row 1: col 0 wins, col 2 ignored.
      do_reset();
      pressed[1][0] = 1'b1;
      pressed[1][2] = 1'b1;
      step(5);
      chk("two nvalid", 4'(nvalid), 4'd1);
      chk("two code", key_code, 4'd4);
      pressed[1][2] = 1'b0;
      step(5);
      chk("two held col2", 4'(key_held), 4'd1);
      pressed[1][0] = 1'b0;
      step(3);
      chk("two held c", 4'(key_held), 4'd1);
      step(1);
      chk("two released", 4'(key_held), 4'd0);

      // Reset asserted mid-debounce on (1,1).
      do_reset();
      pressed[1][1] = 1'b1;
      step(3);
      chk("pre-rst row", row_n, 4'b1101);
      rst_n = 1'b0;
      #1;
      chk("async row_n", row_n, 4'b1110);
      chk("async held", 4'(key_held), 4'd0);
      chk("async valid", 4'(key_valid), 4'd0);

      // ena low mid-debounce freezes count and row.
      do_reset();
      step(3);
      ena = 1'b0;
      step(2);
      repeat (4) @(negedge clk);
      chk("frozen row", row_n, 4'b1101);
      chk("frozen nvalid", 4'(nvalid), 4'd0);
      ena = 1'b1;
      step(1);
      chk("resume nvalid a", 4'(nvalid), 4'd0);
      step(1);
      chk("resume nvalid b", 4'(nvalid), 4'd1);
      chk("resume step", 4'(valid_step), 4'd7);
      chk("resume code", key_code, 4'd5);
      clear_keys();

      // Randomized traffic against the model.
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         if ($urandom_range(0, 2) == 0) begin
            clear_keys();
            for (int j = $urandom_range(0, 2); j > 0; j--)
               pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
         end
         ena = ($urandom_range(0, 9) != 0);
         step(1);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
